// File: rtl/ntsc_pixel_packer.sv
// ntsc_pixel_packer: packs a luminance pixel stream into ZBT write words.
// Each word carries PIX_PER_WORD pixels, slot 0 in the most significant lane.
// A partial word is flushed at sof/sol. Completed words pass through a
// staging register into a small write FIFO with a valid/ready port.
// Build option: define NTSC_PACK_DECIM_EN to build the 2:1 decimation path
// (decim input honoured); otherwise decim is ignored.
module ntsc_pixel_packer #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 4,
  parameter int ROW_W        = 9,
  parameter int WCOL_W       = 8,
  parameter int ADDR_W       = 19,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sof,
  input  logic              field,
  input  logic              sol,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              decim,
  input  logic              ovf_clr,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [35:0]       wr_data,
  output logic              overflow
);
  localparam int DATA_W = PIX_W * PIX_PER_WORD;
  localparam int SLOT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  // Two spare bits: one so wcol overflow stays visible, one for the decimation halving.
  localparam int COL_W  = WCOL_W + SLOT_W + 2;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W  = ADDR_W + 36;
  localparam logic [ROW_W-1:0]  ROW_MAX   = {ROW_W{1'b1}};
  localparam logic [COL_W-1:0]  COL_MAX   = {COL_W{1'b1}};
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PIX_PER_WORD - 1);
  localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  // Word address layout: {zero pad, row, field, word column}.
  function automatic logic [ADDR_W-1:0] make_addr(input logic [ROW_W-1:0] row,
                                                  input logic fld,
                                                  input logic [WCOL_W-1:0] wcol);
    make_addr = ADDR_W'({row, fld, wcol});
  endfunction

  logic dec_s;
`ifdef NTSC_PACK_DECIM_EN
  assign dec_s = decim;
`else
  logic decim_unused_s;
  assign decim_unused_s = decim;
  assign dec_s = 1'b0;
`endif

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              fld_q, fld_d;
  logic              row_sat_q, row_sat_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic              word_drop_q, word_drop_d;
  logic              stage_valid_q, stage_valid_d;
  logic [ADDR_W-1:0] stage_addr_q, stage_addr_d;
  logic [35:0]       stage_data_q, stage_data_d;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              wr_valid_q, wr_valid_d;
  logic              overflow_q, overflow_d;

  logic [COL_W-1:0]  eff_col_s, st_col_s, wcol_full_s;
  logic [ROW_W-1:0]  eff_row_s, st_row_s;
  logic [SLOT_W-1:0] eff_slot_s;
  logic              eff_fld_s, eff_sat_s, flush_s, accept_s, complete_s, wcol_ovf_s;
  logic [DATA_W-1:0] word_next_s;
  logic              pop_s, push_ok_s, ovf_set_s;

  // Line/field bookkeeping, pixel packing and staging of finished words.
  always_comb begin
    eff_col_s  = col_q;
    eff_row_s  = row_q;
    eff_slot_s = slot_q;
    eff_fld_s  = fld_q;
    eff_sat_s  = row_sat_q;
    if (sof) begin
      eff_col_s  = '0;
      eff_row_s  = '0;
      eff_slot_s = '0;
      eff_fld_s  = field;
      eff_sat_s  = 1'b0;
    end else if (sol) begin
      eff_col_s  = '0;
      eff_slot_s = '0;
      if (row_q == ROW_MAX) begin
        eff_sat_s = 1'b1;
      end else begin
        eff_row_s = row_q + ROW_W'(1);
      end
    end else begin
      eff_col_s = col_q;
    end
    // A boundary closes the old line first; the pending word keeps its old address.
    flush_s = (sof || sol) && (slot_q != '0);

    if (dec_s) begin
      st_col_s = {1'b0, eff_col_s[COL_W-1:1]};
      st_row_s = {1'b0, eff_row_s[ROW_W-1:1]};
      accept_s = pix_valid && !eff_col_s[0] && !eff_row_s[0];
    end else begin
      st_col_s = eff_col_s;
      st_row_s = eff_row_s;
      accept_s = pix_valid;
    end
    wcol_full_s = st_col_s >> SLOT_W;
    wcol_ovf_s  = |wcol_full_s[COL_W-1:WCOL_W];

    // Slot 0 starts a fresh word so unfilled lanes read as zero.
    word_next_s = '0;
    for (int s = 0; s < PIX_PER_WORD; s++) begin
      word_next_s[DATA_W-1-s*PIX_W -: PIX_W] =
        (eff_slot_s == SLOT_W'(s)) ? pix_data :
        (eff_slot_s == '0)         ? {PIX_W{1'b0}} :
                                     word_q[DATA_W-1-s*PIX_W -: PIX_W];
    end
    complete_s = accept_s && (eff_slot_s == SLOT_LAST);

    if (pix_valid && (eff_col_s != COL_MAX)) begin
      col_d = eff_col_s + COL_W'(1);
    end else begin
      col_d = eff_col_s;
    end
    row_d       = eff_row_s;
    fld_d       = eff_fld_s;
    row_sat_d   = eff_sat_s;
    word_d      = word_q;
    word_addr_d = word_addr_q;
    word_drop_d = word_drop_q;
    if (accept_s) begin
      word_d = word_next_s;
      if (eff_slot_s == '0) begin
        word_addr_d = make_addr(st_row_s, eff_fld_s, wcol_full_s[WCOL_W-1:0]);
        word_drop_d = wcol_ovf_s || eff_sat_s;
      end else begin
        word_drop_d = word_drop_q;
      end
      slot_d = complete_s ? '0 : eff_slot_s + SLOT_W'(1);
    end else begin
      slot_d = eff_slot_s;
    end

    stage_valid_d = 1'b0;
    stage_addr_d  = stage_addr_q;
    stage_data_d  = stage_data_q;
    if (flush_s) begin
      stage_valid_d = !word_drop_q;
      stage_addr_d  = word_addr_q;
      stage_data_d  = 36'(word_q);
    end else if (complete_s) begin
      stage_valid_d = !word_drop_d;
      stage_addr_d  = word_addr_d;
      stage_data_d  = 36'(word_next_s);
    end else begin
      stage_valid_d = 1'b0;
    end
  end

  // Write FIFO: push from staging, pop on handshake, sticky overflow on a lost word.
  always_comb begin
    pop_s     = wr_valid_q && wr_ready;
    push_ok_s = stage_valid_q && ((count_q != CNT_FULL) || pop_s);
    ovf_set_s = stage_valid_q && (count_q == CNT_FULL) && !pop_s;
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wptr_q] = {stage_addr_q, stage_data_q};
      wptr_d        = wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    wr_valid_d = (count_d != '0);
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Packer and staging state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q         <= '0;
      row_q         <= '0;
      slot_q        <= '0;
      fld_q         <= 1'b0;
      row_sat_q     <= 1'b0;
      word_q        <= '0;
      word_addr_q   <= '0;
      word_drop_q   <= 1'b0;
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      slot_q        <= slot_d;
      fld_q         <= fld_d;
      row_sat_q     <= row_sat_d;
      word_q        <= word_d;
      word_addr_q   <= word_addr_d;
      word_drop_q   <= word_drop_d;
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      stage_data_q  <= stage_data_d;
    end
  end

  // FIFO storage, pointers and output flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      wr_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      wr_valid_q <= wr_valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = mem_q[rptr_q][ENT_W-1 -: ADDR_W];
  assign wr_data  = mem_q[rptr_q][35:0];
  assign overflow = overflow_q;

endmodule

// File: doc/ntsc_pixel_packer.md
# ntsc_pixel_packer

Parametrised successor to the labkit NTSC-to-ZBT path. Packs a decoded luminance pixel stream (already in the system clock domain) into ZBT write words. Word addresses are aligned, so pixel (0,0) lands in word 0 of row 0. Adds partial-word flush at line end, optional 2:1 decimation, and a small write FIFO with a valid/ready handshake toward the ZBT arbiter.

## Interface
- PIX_W, 8, bits per pixel
- PIX_PER_WORD, 4, pixels per ZBT word; PIX_W*PIX_PER_WORD <= 36
- ROW_W, 9, row-index width in address
- WCOL_W, 8, word-column width in address
- ADDR_W, 19, ZBT address width; ROW_W+1+WCOL_W <= ADDR_W
- FIFO_DEPTH, 4, write FIFO entries (power of two, >= 2)

- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sof  in  1  start-of-field pulse; marks column 0 of row 0
- field  in  1  field parity, sampled when sof=1
- sol  in  1  start-of-line pulse (not asserted together with sof for line 0)
- pix_valid  in  1  pixel strobe
- pix_data  in  PIX_W  pixel value
- decim  in  1  2:1 horizontal+vertical decimation select
- ovf_clr  in  1  clears overflow
- wr_valid  out  1  FIFO head valid
- wr_ready  in  1  arbiter accepts head
- wr_addr  out  ADDR_W  head address
- wr_data  out  36  head data
- overflow  out  1  sticky: packed word dropped, FIFO full

## Operation
- Counters: col (pixel column), row (saturates at 2^ROW_W-1), slot (0..PIX_PER_WORD-1), latched fld.
- sof: col=0, row=0, slot=0, fld=field. sol: col=0, slot=0, row=row+1 (saturating). sof wins over sol in the same cycle.
- sof/sol arrives with slot!=0: the pending partial word is flushed. Unfilled slots are zero, and the address is that of the old line.
- sof/sol in the same cycle as pix_valid: the boundary is applied first, and the pixel becomes column 0 of the new line.
- Accepted pixel: written into slot. Slot 0 goes to bits [PIX_W*PIX_PER_WORD-1 -: PIX_W], later slots go toward the LSB, and bits above PIX_W*PIX_PER_WORD are 0. The last slot completes the word.
- Word address is {zero-pad, row[ROW_W-1:0], fld, wcol[WCOL_W-1:0]} with wcol = col_of_slot0 / PIX_PER_WORD.
- Drop rules (drops do not set overflow):
  - Words with wcol > 2^WCOL_W-1 are dropped.
  - Words on the saturated row after saturation are dropped.
- Completed or flushed word goes to a staging register, which pushes to the FIFO on the next edge. At most one push per cycle.
- FIFO:
  - wr_valid = !empty. Pop on wr_valid&&wr_ready.
  - Push when full without a same-cycle pop: the word is dropped and overflow=1.
  - Push when full with a same-cycle pop: the push is accepted.
  - wr_addr/wr_data hold while wr_valid&&!wr_ready.
- overflow clears on ovf_clr. A same-cycle set wins over the clear.
- decim (only effective with the macro): pixels with odd col are skipped and lines with odd row are skipped entirely. Stored coordinates are col/2 and row/2.

## Timing
- Reset: wr_valid=0, wr_addr=0, wr_data=0, overflow=0, counters/slot/fld=0, FIFO empty, staging empty.
- Latency: last pixel of a word sampled at edge N → staging at N → FIFO write at N+1 → wr_valid=1 after N+1 if the FIFO was empty.
- Flush: sof/sol sampled at edge N → same N+1 timing.
- Sustained throughput: one word per PIX_PER_WORD pixels. FIFO absorbs up to FIFO_DEPTH words of wr_ready stall.
- reset_n asserted mid-word or mid-stall: everything discarded immediately, no flush.

## Configuration
- NTSC_PACK_DECIM_EN defined: decimation logic built, and decim is honoured.
- Not defined: decim is ignored (treated as 0) and no decimation logic is synthesised.

## Test plan
- Reset, then sof(field=0), pixels 0x01..0x08, wr_ready=1 → words {addr 0x000000, data 0x01020304} and {addr 0x000001, data 0x05060708}. First wr_valid rises 2 edges after the 4th pixel.
- sof(field=1), 6 pixels 0xA0..0xA5, sol, 1 pixel 0xB0 → words 0x0100:0xA0A1A2A3, 0x0101:0xA4A50000, then after sol row 1 appends 0xB0 at addr 0x0300.
- wr_ready=0, push 5 words with FIFO_DEPTH=4 → 4 held with wr_addr stable, overflow=1. ovf_clr then wr_ready=1 → 4 words drain in order, overflow=0.
- With NTSC_PACK_DECIM_EN, decim=1, row 0 pixels 0..7 = 0x10..0x17 → single word 0x10121416 at addr 0. Row 1 produces no words.
- Assert reset_n low with 3 pixels pending and 2 words queued → wr_valid=0 asynchronously. No stale word appears after release.
- Pixel 1024 onward with WCOL_W=8, PIX_PER_WORD=4 → no words emitted, overflow stays 0.
